// File: rtl/vga2_zcmp.sv
// VGA2 rasteriser Z-compare stage: depth test with forwarding, Z write-back
// strobes, a small output FIFO for passing pixels and pass/fail statistics.
module vga2_zcmp #(
    parameter int unsigned ZW    = 12,
    parameter int unsigned XW    = 10,
    parameter int unsigned PW    = 72,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [2:0]    cfg_zfunc,
    input  logic          cfg_zwrite,
    input  logic          clear_counts,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [ZW-1:0] in_z,
    input  logic [PW-1:0] in_payload,
    input  logic [ZW-1:0] fetched_z,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [ZW-1:0] out_z,
    output logic [PW-1:0] out_payload,
    output logic          zw_valid,
    output logic [XW-1:0] zw_x,
    output logic [ZW-1:0] zw_z,
    output logic [CW-1:0] pass_count,
    output logic [CW-1:0] fail_count,
    output logic          busy
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic          s_valid;
    logic          s_pass;
    logic [XW-1:0] s_x;
    logic [ZW-1:0] s_z;
    logic [PW-1:0] s_payload;

    logic [AW:0]   fifo_count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [XW-1:0] mem_x       [DEPTH];
    logic [ZW-1:0] mem_z       [DEPTH];
    logic [PW-1:0] mem_payload [DEPTH];

    logic          s_leave;
    logic          accept;
    logic          push;
    logic          pop;
    logic [ZW-1:0] ref_z;
    logic          cmp_pass;

    // fifo_count is registered, so in_ready never depends on out_ready combinationally
    assign s_leave   = s_valid && (!s_pass || (fifo_count < FULL));
    assign in_ready  = !s_valid || s_leave;
    assign accept    = in_valid && in_ready;
    assign push      = s_leave && s_pass;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign busy      = s_valid || (fifo_count != '0);

    assign out_x       = mem_x[rd_ptr];
    assign out_z       = mem_z[rd_ptr];
    assign out_payload = mem_payload[rd_ptr];

    // The pixel in S will be written next cycle, the zw register is being written now;
    // both are newer than what the Z-fetch stage could have seen.
    always_comb begin
        ref_z = fetched_z;
        if (s_valid && s_pass && cfg_zwrite && (s_x == in_x)) begin
            ref_z = s_z;
        end else if (zw_valid && (zw_x == in_x)) begin
            ref_z = zw_z;
        end
    end

    always_comb begin
        cmp_pass = 1'b0;
        case (cfg_zfunc)
            3'd0:    cmp_pass = 1'b0;
            3'd1:    cmp_pass = (in_z <  ref_z);
            3'd2:    cmp_pass = (in_z == ref_z);
            3'd3:    cmp_pass = (in_z <= ref_z);
            3'd4:    cmp_pass = (in_z >  ref_z);
            3'd5:    cmp_pass = (in_z != ref_z);
            3'd6:    cmp_pass = (in_z >= ref_z);
            default: cmp_pass = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_valid <= 1'b0;
            s_pass  <= 1'b0;
        end else if (accept) begin
            s_valid <= 1'b1;
            s_pass  <= cmp_pass;
        end else if (s_leave) begin
            s_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s_x       <= in_x;
            s_z       <= in_z;
            s_payload <= in_payload;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_x[wr_ptr]       <= s_x;
            mem_z[wr_ptr]       <= s_z;
            mem_payload[wr_ptr] <= s_payload;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zw_valid <= 1'b0;
        end else begin
            zw_valid <= push && cfg_zwrite;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            zw_x <= s_x;
            zw_z <= s_z;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (clear_counts) begin
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            if (push && (pass_count != '1)) pass_count <= pass_count + 1'b1;
            if (s_leave && !s_pass && (fail_count != '1)) fail_count <= fail_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga2_zcmp.sv
// Scoreboard bench for vga2_zcmp: expected pixels and Z writes are queued at
// acceptance and compared as the FIFO head and zw strobe appear.
module tb_vga2_zcmp;

    localparam int unsigned ZW    = 12;
    localparam int unsigned XW    = 10;
    localparam int unsigned PW    = 72;
    localparam int unsigned DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [2:0]    cfg_zfunc;
    logic          cfg_zwrite;
    logic          clear_counts;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [ZW-1:0] in_z;
    logic [PW-1:0] in_payload;
    logic [ZW-1:0] fetched_z;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_x;
    logic [ZW-1:0] out_z;
    logic [PW-1:0] out_payload;
    logic          zw_valid;
    logic [XW-1:0] zw_x;
    logic [ZW-1:0] zw_z;
    logic [15:0]   pass_count;
    logic [15:0]   fail_count;
    logic          busy;

    logic          c4_in_ready;
    logic          c4_out_valid;
    logic [XW-1:0] c4_out_x;
    logic [ZW-1:0] c4_out_z;
    logic [PW-1:0] c4_out_payload;
    logic          c4_zw_valid;
    logic [XW-1:0] c4_zw_x;
    logic [ZW-1:0] c4_zw_z;
    logic [3:0]    c4_pass_count;
    logic [3:0]    c4_fail_count;
    logic          c4_busy;

    always #5 clock = ~clock;

    vga2_zcmp #(.ZW(ZW), .XW(XW), .PW(PW), .DEPTH(DEPTH), .CW(16)) dut (
        .clock(clock), .reset(reset), .cfg_zfunc(cfg_zfunc), .cfg_zwrite(cfg_zwrite),
        .clear_counts(clear_counts), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_z(in_z), .in_payload(in_payload), .fetched_z(fetched_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_z(out_z),
        .out_payload(out_payload), .zw_valid(zw_valid), .zw_x(zw_x), .zw_z(zw_z),
        .pass_count(pass_count), .fail_count(fail_count), .busy(busy)
    );

    // Narrow-counter build sharing the same stimulus, used for saturation
    vga2_zcmp #(.ZW(ZW), .XW(XW), .PW(PW), .DEPTH(DEPTH), .CW(4)) dut_c4 (
        .clock(clock), .reset(reset), .cfg_zfunc(cfg_zfunc), .cfg_zwrite(cfg_zwrite),
        .clear_counts(clear_counts), .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_x(in_x), .in_z(in_z), .in_payload(in_payload), .fetched_z(fetched_z),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out_x(c4_out_x), .out_z(c4_out_z),
        .out_payload(c4_out_payload), .zw_valid(c4_zw_valid), .zw_x(c4_zw_x), .zw_z(c4_zw_z),
        .pass_count(c4_pass_count), .fail_count(c4_fail_count), .busy(c4_busy)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [ZW-1:0] z;
        logic [PW-1:0] p;
    } beat_t;

    beat_t               expq[$];
    logic [XW+ZW-1:0]    zwq[$];
    int unsigned         n_checks = 0;
    int unsigned         n_errors = 0;
    int                  cyc = 0;
    int                  first_out = -1;
    int                  last_acc = 0;
    int                  out_seen = 0;
    int                  zw_seen = 0;
    logic [XW-1:0]       xseq = 10'd100;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Compare codes are a mask of {greater, equal, less}
    function automatic bit zpass(input logic [2:0] f, input logic [ZW-1:0] a, input logic [ZW-1:0] b);
        if (a < b)       return f[0];
        else if (a == b) return f[1];
        else             return f[2];
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                out_seen++;
                if (expq.size() == 0) check("out_unexpected", 1, 0);
                else check("out_data", {out_x, out_z, out_payload}, expq.pop_front());
            end
            if (zw_valid) begin
                zw_seen++;
                if (zwq.size() == 0) check("zw_unexpected", 1, 0);
                else check("zw_data", {zw_x, zw_z}, zwq.pop_front());
            end
        end
    end

    task automatic send(input logic [XW-1:0] x, input logic [ZW-1:0] z,
                        input logic [ZW-1:0] fz, input logic [ZW-1:0] refz);
        beat_t b;
        bit    ok;
        ok  = 1'b0;
        b.x = x;
        b.z = z;
        b.p = {8'($urandom()), $urandom(), $urandom()};
        in_valid = 1'b1; in_x = x; in_z = z; fetched_z = fz; in_payload = b.p;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            last_acc = cyc;
            if (zpass(cfg_zfunc, z, refz)) begin
                expq.push_back(b);
                if (cfg_zwrite) zwq.push_back({x, z});
            end
        end else begin
            check("accept_timeout", 0, 1);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [ZW-1:0] z, input logic [ZW-1:0] fz);
        send(xseq, z, fz, fz);
        xseq = xseq + 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (!busy && expq.size() == 0 && zwq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge clock); #1;
    endtask

    task automatic clr();
        clear_counts = 1'b1;
        @(posedge clock); #1;
        clear_counts = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int os0;
        int zs0;
        logic [2:0] fv;

        reset = 1'b1; cfg_zfunc = 3'd1; cfg_zwrite = 1'b1; clear_counts = 1'b0;
        in_valid = 1'b0; in_x = '0; in_z = '0; in_payload = '0; fetched_z = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_zw_valid", zw_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // In-order stream, all passing, latency of first output
        first_out = -1; out_seen = 0; zw_seen = 0;
        for (int i = 0; i < 8; i++) begin
            send(10'(i), 12'd5, 12'd9, 12'd9);
            if (i == 0) t0 = last_acc;
        end
        drain();
        check("t1_latency", first_out - t0, 2);
        check("t1_outputs", out_seen, 8);
        check("t1_zw", zw_seen, 8);
        check("t1_pass", pass_count, 8);
        check("t1_fail", fail_count, 0);

        // All rejected; stage idle two cycles after the last beat
        clr();
        os0 = out_seen; zs0 = zw_seen;
        for (int i = 0; i < 4; i++) send_seq(12'd9, 12'd5);
        @(posedge clock); #1;
        check("t2_busy", busy, 0);
        check("t2_out_valid", out_valid, 0);
        check("t2_fail", fail_count, 4);
        check("t2_pass", pass_count, 0);
        check("t2_no_out", out_seen - os0, 0);
        check("t2_no_zw", zw_seen - zs0, 0);

        // Same-X hazards: forward from S, then from the zw register
        clr();
        send(10'd3, 12'd7, 12'd10, 12'd10);
        send(10'd3, 12'd6, 12'd10, 12'd7);
        send(10'd3, 12'd8, 12'd10, 12'd6);
        send(10'd3, 12'd6, 12'd10, 12'd6);
        drain();
        check("t3_pass", pass_count, 2);
        check("t3_fail", fail_count, 2);

        // Backpressure: FIFO fills, S holds one, input stalls
        clr();
        os0 = out_seen;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_seq(12'd5, 12'd9);
            end
            begin
                repeat (20) @(negedge clock);
                check("t4_in_ready", in_ready, 0);
                check("t4_pass_held", pass_count, 4);
                check("t4_out_valid", out_valid, 1);
                check("t4_busy", busy, 1);
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("t4_outputs", out_seen - os0, 8);
        check("t4_pass", pass_count, 8);

        // Asynchronous reset with entries in the FIFO
        clr();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_seq(12'd5, 12'd9);
        repeat (4) @(posedge clock);
        #1;
        check("t5_pre_valid", out_valid, 1);
        check("t5_pre_pass", pass_count, 3);
        #2;
        reset = 1'b1;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_pass", pass_count, 0);
        check("t5_fail", fail_count, 0);
        check("t5_zw_valid", zw_valid, 0);
        check("t5_in_ready", in_ready, 1);
        expq.delete();
        zwq.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;

        // Saturation on the 4-bit build, then clear racing an increment
        cfg_zfunc = 3'd7;
        clr();
        for (int i = 0; i < 17; i++) send_seq(12'd100, 12'd50);
        drain();
        check("t6_c4_sat", c4_pass_count, 15);
        check("t6_pass17", pass_count, 17);
        send_seq(12'd100, 12'd50);
        clear_counts = 1'b1;
        @(posedge clock); #1;
        clear_counts = 1'b0;
        check("t6_clr_pass", pass_count, 0);
        check("t6_clr_c4", c4_pass_count, 0);
        drain();
        check("t6_after_clr", pass_count, 0);

        // Every compare function against less/equal/greater; zwrite on odd codes
        clr();
        for (int f = 0; f < 8; f++) begin
            fv = 3'(f);
            cfg_zfunc = fv;
            cfg_zwrite = fv[0];
            send_seq(12'd10, 12'd20);
            send_seq(12'd20, 12'd20);
            send_seq(12'd30, 12'd20);
            drain();
        end
        check("t7_pass", pass_count, 12);
        check("t7_fail", fail_count, 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
